// File: rtl/uart_tx_scheduler_if.sv
// Byte handshake between the TX scheduler and the uiuart_tx driver.
interface uart_tx_scheduler_if;
    logic       O_tx_wreq;
    logic [7:0] O_tx_wdata;
    logic       I_tx_wbusy;

    modport master (output O_tx_wreq, output O_tx_wdata, input I_tx_wbusy);
    modport slave  (input O_tx_wreq, input O_tx_wdata, output I_tx_wbusy);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one uiuart_tx between the RX echo FIFO and a 4-byte status-report frame,
// round-robin arbitrated, one byte per wreq/wbusy handshake.
module uart_tx_scheduler #(
    parameter int         FIFO_AW   = 2,
    parameter int         BUSY_TO   = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 I_sysclk,
    input  logic                 uart_rstn_i,
    input  logic                 I_echo_valid,
    input  logic [7:0]           I_echo_data,
    input  logic                 I_report_req,
    input  logic                 I_split_full_flag,
    input  logic [3:0]           I_screen_switch,
    uart_tx_scheduler_if.master  tx_if,
    output logic                 O_echo_drop,
    output logic                 O_report_busy,
    output logic [FIFO_AW:0]     O_fifo_level
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TO_W  = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               pend_q, pend_d, pend_split_q, pend_split_d;
    logic [3:0]         pend_screen_q, pend_screen_d, frm_screen_q, frm_screen_d;
    logic               frm_split_q, frm_split_d, in_frame_q, in_frame_d;
    logic [1:0]         idx_q, idx_d;
    logic               last_rep_q, last_rep_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               wreq_q, wreq_d, drop_q, drop_d, rbusy_q, rbusy_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               pop_s, wr_ok_s, full_s, pend_clr_s, byte_done_s;

    // Checksum byte is the XOR of the mode and screen bytes.
    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic split,
                                              input logic [3:0] screen);
        logic [7:0] b1, b2;
        b1 = {7'b0000000, split};
        b2 = {4'b0000, screen};
        case (idx)
            2'd0:    return SYNC_BYTE;
            2'd1:    return b1;
            2'd2:    return b2;
            2'd3:    return b1 ^ b2;
            default: return 8'h00;
        endcase
    endfunction

    // Next-state logic for arbitration, handshake sequencing, echo FIFO and report pending.
    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pend_d        = pend_q;
        pend_split_d  = pend_split_q;
        pend_screen_d = pend_screen_q;
        frm_split_d   = frm_split_q;
        frm_screen_d  = frm_screen_q;
        in_frame_d    = in_frame_q;
        idx_d         = idx_q;
        last_rep_d    = last_rep_q;
        to_cnt_d      = to_cnt_q;
        wdata_d       = wdata_q;
        wreq_d        = 1'b0;
        pop_s         = 1'b0;
        pend_clr_s    = 1'b0;
        byte_done_s   = 1'b0;
        full_s        = (level_q == (FIFO_AW+1)'(DEPTH));

        case (state_q)
            S_IDLE: begin
                if (!tx_if.I_tx_wbusy && (level_q != '0) && (!pend_q || last_rep_q)) begin
                    pop_s      = 1'b1;
                    wdata_d    = mem_q[rd_ptr_q];
                    last_rep_d = 1'b0;
                    wreq_d     = 1'b1;
                    state_d    = S_ISSUE;
                end else if (!tx_if.I_tx_wbusy && pend_q) begin
                    frm_split_d  = pend_split_q;
                    frm_screen_d = pend_screen_q;
                    pend_clr_s   = 1'b1;
                    idx_d        = 2'd0;
                    in_frame_d   = 1'b1;
                    last_rep_d   = 1'b1;
                    wdata_d      = SYNC_BYTE;
                    wreq_d       = 1'b1;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_if.I_tx_wbusy) begin
                    state_d = S_WAIT_LO;
                end else if (to_cnt_q == TO_W'(BUSY_TO - 1)) begin
                    byte_done_s = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT_LO: begin
                if (!tx_if.I_tx_wbusy) begin
                    byte_done_s = 1'b1;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A silent driver (timeout) completes the byte exactly like a falling wbusy.
        if (byte_done_s && in_frame_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            wdata_d = frame_byte(idx_q + 2'd1, frm_split_q, frm_screen_q);
            wreq_d  = 1'b1;
            state_d = S_ISSUE;
        end else if (byte_done_s) begin
            in_frame_d = 1'b0;
            state_d    = S_IDLE;
        end else begin
            in_frame_d = in_frame_d;
        end

        wr_ok_s = I_echo_valid && (!full_s || pop_s);
        drop_d  = I_echo_valid && !wr_ok_s;
        if (wr_ok_s) begin
            mem_d[wr_ptr_q] = I_echo_data;
            wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + (FIFO_AW+1)'(wr_ok_s) - (FIFO_AW+1)'(pop_s);

        // A request arriving at frame start becomes the next pending frame.
        if (I_report_req) begin
            pend_d        = 1'b1;
            pend_split_d  = I_split_full_flag;
            pend_screen_d = I_screen_switch;
        end else if (pend_clr_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        rbusy_d = pend_d | in_frame_d;
    end

    // State and output registers.
    always_ff @(posedge I_sysclk or negedge uart_rstn_i) begin
        if (!uart_rstn_i) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            pend_q        <= 1'b0;
            pend_split_q  <= 1'b0;
            pend_screen_q <= 4'h0;
            frm_split_q   <= 1'b0;
            frm_screen_q  <= 4'h0;
            in_frame_q    <= 1'b0;
            idx_q         <= 2'd0;
            last_rep_q    <= 1'b1;
            to_cnt_q      <= '0;
            wreq_q        <= 1'b0;
            wdata_q       <= 8'h00;
            drop_q        <= 1'b0;
            rbusy_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            pend_q        <= pend_d;
            pend_split_q  <= pend_split_d;
            pend_screen_q <= pend_screen_d;
            frm_split_q   <= frm_split_d;
            frm_screen_q  <= frm_screen_d;
            in_frame_q    <= in_frame_d;
            idx_q         <= idx_d;
            last_rep_q    <= last_rep_d;
            to_cnt_q      <= to_cnt_d;
            wreq_q        <= wreq_d;
            wdata_q       <= wdata_d;
            drop_q        <= drop_d;
            rbusy_q       <= rbusy_d;
        end
    end

    assign tx_if.O_tx_wreq  = wreq_q;
    assign tx_if.O_tx_wdata = wdata_q;
    assign O_echo_drop      = drop_q;
    assign O_report_busy    = rbusy_q;
    assign O_fifo_level     = level_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler: a queue-based reference model predicts every
// transmitted byte, FIFO level and drop pulse; directed scenarios pin the model with literals.
module tb_uart_tx_scheduler;
    localparam int FIFO_AW = 2;
    localparam int BUSY_TO = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             echo_valid, report_req, split;
    logic [7:0]       echo_data;
    logic [3:0]       screen;
    logic             echo_drop, report_busy;
    logic [FIFO_AW:0] fifo_level;

    uart_tx_scheduler_if tx_if ();

    uart_tx_scheduler #(.FIFO_AW(FIFO_AW), .BUSY_TO(BUSY_TO), .SYNC_BYTE(8'hA5)) dut (
        .I_sysclk(clk), .uart_rstn_i(rstn), .I_echo_valid(echo_valid), .I_echo_data(echo_data),
        .I_report_req(report_req), .I_split_full_flag(split), .I_screen_switch(screen),
        .tx_if(tx_if), .O_echo_drop(echo_drop), .O_report_busy(report_busy),
        .O_fifo_level(fifo_level));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] q_echo[$];
    logic       pend, psplit, last_rep, exp_drop, prev_wreq;
    logic [3:0] pscreen;
    logic [7:0] frame [4];
    int         fidx;
    logic [7:0] sent[$];
    int         wreq_cyc[$];
    int         cycle, drops;
    // driver model
    int         txmode, tx_rise, tx_left, tx_fixed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        q_echo.delete();
        pend = 1'b0; psplit = 1'b0; pscreen = 4'h0; last_rep = 1'b1;
        exp_drop = 1'b0; prev_wreq = 1'b0; fidx = 0;
        tx_rise = -1; tx_left = 0;
        tx_if.I_tx_wbusy = 1'b0;
    endtask

    task automatic step();
        logic       c_ev, c_rr, c_sp, have, er;
        logic [7:0] c_ed, exp;
        logic [3:0] c_sc;
        c_ev = echo_valid; c_ed = echo_data; c_rr = report_req; c_sp = split; c_sc = screen;
        @(posedge clk);
        #1;
        cycle++;
        if (tx_if.O_tx_wreq) begin
            chk("wreq_one_cycle", prev_wreq, 1'b0);
            chk("wreq_while_busy", tx_if.I_tx_wbusy, 1'b0);
            have = 1'b1;
            exp  = 8'h00;
            er   = (q_echo.size() > 0);
            if (fidx >= 1 && fidx <= 3) begin
                exp = frame[fidx];
                fidx++;
            end else if (er && (!pend || last_rep)) begin
                exp = q_echo.pop_front();
                last_rep = 1'b0;
            end else if (pend) begin
                frame[0] = 8'hA5;
                frame[1] = {7'd0, psplit};
                frame[2] = {4'd0, pscreen};
                frame[3] = frame[1] ^ frame[2];
                exp = frame[0]; fidx = 1; pend = 1'b0; last_rep = 1'b1;
            end else begin
                have = 1'b0;
            end
            chk("wreq_expected", have, 1'b1);
            chk("wdata", tx_if.O_tx_wdata, exp);
            sent.push_back(tx_if.O_tx_wdata);
            wreq_cyc.push_back(cycle);
        end
        prev_wreq = tx_if.O_tx_wreq;
        exp_drop = 1'b0;
        if (c_ev) begin
            if (q_echo.size() < (1 << FIFO_AW)) q_echo.push_back(c_ed);
            else exp_drop = 1'b1;
        end
        if (c_rr) begin
            pend = 1'b1; psplit = c_sp; pscreen = c_sc;
        end
        chk("fifo_level", fifo_level, q_echo.size());
        chk("echo_drop", echo_drop, exp_drop);
        if (echo_drop) drops++;
        if (pend || (fidx >= 1 && fidx <= 3)) chk("report_busy", report_busy, 1'b1);
        // uiuart_tx stand-in: optional 1-cycle rise delay, then busy for a few cycles
        if (tx_if.O_tx_wreq && txmode == 0) begin
            tx_rise = (tx_fixed > 0) ? 0 : $urandom_range(0, 1);
            tx_left = (tx_fixed > 0) ? tx_fixed : $urandom_range(1, 6);
        end
        if (tx_rise >= 0) begin
            if (tx_rise == 0) begin
                tx_if.I_tx_wbusy = 1'b1;
                tx_rise = -1;
            end else begin
                tx_rise--;
            end
        end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) tx_if.I_tx_wbusy = 1'b0;
        end
        echo_valid = 1'b0;
        report_req = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        echo_valid = 1'b0; report_req = 1'b0; split = 1'b0; screen = 4'h0; echo_data = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sent.delete(); wreq_cyc.delete(); drops = 0;
    endtask

    task automatic wait_sent(input int k);
        int n = 0;
        while (sent.size() < k && n < 500) begin
            step();
            n++;
        end
        chk("wait_sent_timeout", (sent.size() >= k), 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (!(q_echo.size() == 0 && !pend && (fidx == 0 || fidx == 4) && tx_rise < 0 &&
                 tx_left == 0 && !tx_if.I_tx_wbusy) && n < 2000) begin
            step();
            n++;
        end
        repeat (BUSY_TO + 4) step();
        chk("drain_timeout", (n < 2000), 1'b1);
        chk("idle_report_busy", report_busy, 1'b0);
        chk("idle_fifo_level", fifo_level, 0);
    endtask

    task automatic chk_seq(input string name, input logic [7:0] exp_q[$]);
        chk({name, "_count"}, sent.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++) chk(name, sent[i], exp_q[i]);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        cycle = 0; txmode = 0; tx_fixed = 0; drops = 0;
        rstn = 1'b0;
        model_reset();
        #2;
        chk("rst_wreq", tx_if.O_tx_wreq, 1'b0);
        chk("rst_wdata", tx_if.O_tx_wdata, 8'h00);
        chk("rst_drop", echo_drop, 1'b0);
        chk("rst_report_busy", report_busy, 1'b0);
        chk("rst_level", fifo_level, 0);

        // 1: single echo latency, driver busy 10 cycles
        do_reset();
        tx_fixed = 10;
        echo_valid = 1'b1; echo_data = 8'h3C;
        step();
        chk("t1_level_after_write", fifo_level, 1);
        chk("t1_no_wreq_yet", tx_if.O_tx_wreq, 1'b0);
        step();
        chk("t1_wreq_cycle2", tx_if.O_tx_wreq, 1'b1);
        chk("t1_wdata", tx_if.O_tx_wdata, 8'h3C);
        chk("t1_level_after_pop", fifo_level, 0);
        drain();
        exp_q = '{8'h3C};
        chk_seq("t1_seq", exp_q);

        // 2: one report frame
        do_reset();
        report_req = 1'b1; split = 1'b1; screen = 4'h2;
        step();
        drain();
        exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03};
        chk_seq("t2_seq", exp_q);

        // 3: tie from reset goes to echo; echo arriving mid-frame waits for the frame
        do_reset();
        echo_valid = 1'b1; echo_data = 8'h11; report_req = 1'b1; split = 1'b0; screen = 4'h5;
        step();
        wait_sent(2);
        echo_valid = 1'b1; echo_data = 8'h22;
        step();
        drain();
        exp_q = '{8'h11, 8'hA5, 8'h00, 8'h05, 8'h05, 8'h22};
        chk_seq("t3_seq", exp_q);

        // 4: six echoes during a frame: four queued, two dropped
        do_reset();
        report_req = 1'b1; split = 1'b0; screen = 4'h7;
        step();
        wait_sent(1);
        for (int i = 0; i < 6; i++) begin
            echo_valid = 1'b1; echo_data = 8'h31 + 8'(i);
            step();
        end
        step();
        chk("t4_level_full", fifo_level, 4);
        drain();
        chk("t4_drops", drops, 2);
        exp_q = '{8'hA5, 8'h00, 8'h07, 8'h07, 8'h31, 8'h32, 8'h33, 8'h34};
        chk_seq("t4_seq", exp_q);

        // 5: three requests during one frame coalesce into one frame with the last snapshot
        do_reset();
        report_req = 1'b1; split = 1'b1; screen = 4'h9;
        step();
        wait_sent(1);
        for (int i = 1; i <= 3; i++) begin
            report_req = 1'b1; split = 1'b1; screen = 4'(i);
            step();
            step();
        end
        drain();
        exp_q = '{8'hA5, 8'h01, 8'h09, 8'h08, 8'hA5, 8'h01, 8'h03, 8'h02};
        chk_seq("t5_seq", exp_q);

        // 6: driver never raises busy -> timeout pacing; reset mid-frame abandons everything
        do_reset();
        tx_fixed = 0; txmode = 1;
        report_req = 1'b1; split = 1'b1; screen = 4'h4;
        step();
        wait_sent(3);
        chk("t6_pace_01", wreq_cyc[1] - wreq_cyc[0], BUSY_TO + 1);
        chk("t6_pace_12", wreq_cyc[2] - wreq_cyc[1], BUSY_TO + 1);
        chk("t6_byte2", sent[2], 8'h04);
        echo_valid = 1'b1; echo_data = 8'h55;
        step();
        echo_valid = 1'b1; echo_data = 8'h66;
        step();
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_wreq", tx_if.O_tx_wreq, 1'b0);
        chk("t6_rst_wdata", tx_if.O_tx_wdata, 8'h00);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_report_busy", report_busy, 1'b0);
        chk("t6_rst_drop", echo_drop, 1'b0);
        model_reset();
        sent.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (20) step();
        chk("t6_no_resume", sent.size(), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) txmode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            echo_valid = ($urandom_range(0, 3) == 0);
            echo_data  = 8'($urandom);
            report_req = ($urandom_range(0, 15) == 0);
            split      = 1'($urandom);
            screen     = 4'($urandom);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
